// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Brief    : Source side of a 4-phase req/ack handshake carrying WIDTH-bit
//            words into another clock domain, with synchronized ack and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
    parameter int WIDTH          = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [c_CNT_W-1:0] c_TO_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_req;
    logic                   w_req_nxt;
    logic [WIDTH-1:0]       r_data;
    logic [WIDTH-1:0]       w_data_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_sync;
    logic                   w_in_ready;

    // ack_in is asynchronous; only the last stage of this chain feeds logic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
    assign w_in_ready = (r_state == S_IDLE) && !w_ack_sync;

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err & ~err_clr;
        case (r_state)
            S_IDLE: begin
                if (in_valid && w_in_ready) begin
                    w_data_nxt  = in_data;
                    w_req_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (r_cnt != c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
                // A real ack takes priority over a timeout in the same cycle
                if (w_ack_sync) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_RELEASE;
                end else if (c_TO_EN && (r_cnt == c_TO_LAST)) begin
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!w_ack_sync) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign in_ready    = w_in_ready;
    assign req_out     = r_req;
    assign data_out    = r_data;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Brief    : Directed self-checking bench for cdc_handshake_tx (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: defaults; B: TIMEOUT_CYCLES=8; C: TIMEOUT_CYCLES=4
    logic        a_valid, a_ready, a_req, a_ack, a_busy, a_err, a_clr;
    logic [15:0] a_din, a_dout;
    logic        b_valid, b_ready, b_req, b_ack, b_busy, b_err, b_clr;
    logic [15:0] b_din, b_dout;
    logic        c_valid, c_ready, c_req, c_ack, c_busy, c_err, c_clr;
    logic [15:0] c_din, c_dout;

    cdc_handshake_tx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)) u_dut_a (
        .clk(clk), .reset(rst), .in_valid(a_valid), .in_data(a_din), .in_ready(a_ready),
        .req_out(a_req), .data_out(a_dout), .ack_in(a_ack), .busy(a_busy),
        .timeout_err(a_err), .err_clr(a_clr));
    cdc_handshake_tx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) u_dut_b (
        .clk(clk), .reset(rst), .in_valid(b_valid), .in_data(b_din), .in_ready(b_ready),
        .req_out(b_req), .data_out(b_dout), .ack_in(b_ack), .busy(b_busy),
        .timeout_err(b_err), .err_clr(b_clr));
    cdc_handshake_tx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(4)) u_dut_c (
        .clk(clk), .reset(rst), .in_valid(c_valid), .in_data(c_din), .in_ready(c_ready),
        .req_out(c_req), .data_out(c_dout), .ack_in(c_ack), .busy(c_busy),
        .timeout_err(c_err), .err_clr(c_clr));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] words [3] = '{16'h0001, 16'h0002, 16'h0003};
    int          idx, n_seen, viol, rcnt;
    logic        prev_req, acc, done;
    logic [15:0] held;

    initial begin
        rst = 1'b1;
        {a_valid, a_ack, a_clr, b_valid, b_ack, b_clr, c_valid, c_ack, c_clr} = '0;
        a_din = '0; b_din = '0; c_din = '0;
        tick(2);
        check("rst_req",   a_req,   0);
        check("rst_data",  a_dout,  0);
        check("rst_busy",  a_busy,  0);
        check("rst_err",   a_err,   0);
        check("rst_ready", a_ready, 1);
        rst = 1'b0;
        tick(1);

        // Single word: accept at edge 0, ack at 5, ack drop at 10
        a_valid = 1'b1; a_din = 16'hA5C3;
        tick(1);
        a_valid = 1'b0;
        check("t1_req",   a_req,   1);
        check("t1_data",  a_dout,  16'hA5C3);
        check("t1_ready", a_ready, 0);
        check("t1_busy",  a_busy,  1);
        tick(5);
        a_ack = 1'b1;
        tick(2);
        check("t1_req_hold", a_req, 1);
        tick(1);
        check("t1_req_fall",  a_req,  0);
        check("t1_data_hold", a_dout, 16'hA5C3);
        tick(2);
        a_ack = 1'b0;
        tick(2);
        check("t1_ready_lo", a_ready, 0);
        tick(1);
        check("t1_ready_hi",  a_ready, 1);
        check("t1_busy_lo",   a_busy,  0);
        check("t1_idle_data", a_dout,  16'hA5C3);

        // Back-to-back with a responder acking 3 cycles after req is seen
        idx = 0; n_seen = 0; viol = 0; rcnt = 0; prev_req = 1'b0; done = 1'b0; held = '0;
        a_valid = 1'b1; a_din = words[0];
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            acc = a_valid && a_ready;
            tick(1);
            if (acc) begin
                idx++;
                if (idx < 3) a_din = words[idx];
                else         a_valid = 1'b0;
            end
            if (a_busy && a_ready) viol++;
            if (a_req && !prev_req) begin
                if (n_seen < 3) check($sformatf("b2b_word%0d", n_seen), a_dout, words[n_seen]);
                else            viol++;
                held = a_dout;
                n_seen++;
                rcnt = 0;
            end else if (a_req && a_dout !== held) begin
                viol++;
            end
            if (a_req) begin
                rcnt++;
                if (rcnt == 3) a_ack = 1'b1;
            end else begin
                a_ack = 1'b0;
            end
            prev_req = a_req;
            if (n_seen == 3 && a_ready && !a_busy) done = 1'b1;
        end
        a_valid = 1'b0; a_ack = 1'b0;
        check("b2b_done", done, 1);
        check("b2b_viol", viol, 0);

        // Timeout with TIMEOUT_CYCLES=8
        b_valid = 1'b1; b_din = 16'h0BAD;
        tick(1);
        b_valid = 1'b0;
        tick(7);
        check("to_req_hold", b_req, 1);
        check("to_err_lo",   b_err, 0);
        tick(1);
        check("to_req_fall", b_req,  0);
        check("to_err_set",  b_err,  1);
        check("to_busy",     b_busy, 1);
        tick(1);
        check("to_ready",  b_ready, 1);
        check("to_sticky", b_err,   1);
        b_clr = 1'b1;
        tick(1);
        b_clr = 1'b0;
        check("to_clr", b_err, 0);
        b_valid = 1'b1; b_din = 16'h1234;
        tick(1);
        b_valid = 1'b0;
        check("to_next_req",  b_req,  1);
        check("to_next_data", b_dout, 16'h1234);
        b_ack = 1'b1;
        tick(3);
        check("to_next_fall", b_req, 0);
        check("to_next_err",  b_err, 0);
        b_ack = 1'b0;
        tick(3);
        check("to_next_ready", b_ready, 1);
        // Set beats a clear held through the timeout edge
        b_valid = 1'b1; b_din = 16'h5555;
        tick(1);
        b_valid = 1'b0; b_clr = 1'b1;
        tick(7);
        check("to_clr_held", b_err, 0);
        tick(1);
        check("to_set_wins", b_err, 1);
        b_clr = 1'b0;
        tick(2);

        // Ack/timeout collision with TIMEOUT_CYCLES=4
        c_valid = 1'b1; c_din = 16'hC0DE;
        tick(1);
        c_valid = 1'b0;
        tick(1);
        c_ack = 1'b1;
        tick(2);
        check("col_req_hold", c_req, 1);
        tick(1);
        check("col_req_fall", c_req,  0);
        check("col_err",      c_err,  0);
        check("col_busy",     c_busy, 1);
        c_ack = 1'b0;
        tick(3);
        check("col_ready",    c_ready, 1);
        check("col_err_after", c_err,  0);

        // Reset asserted between edges while req_out=1
        a_valid = 1'b1; a_din = 16'h7E57;
        tick(1);
        a_valid = 1'b0;
        check("mr_req", a_req, 1);
        #3 rst = 1'b1;
        a_ack = 1'b1;
        #1;
        check("mr_req0",  a_req,  0);
        check("mr_data0", a_dout, 0);
        check("mr_busy0", a_busy, 0);
        tick(2);
        rst = 1'b0;

        // Stale ack held high across reset release
        tick(2);
        check("st_ready_lo", a_ready, 0);
        a_valid = 1'b1; a_din = 16'hBEEF;
        tick(3);
        check("st_ignored_busy", a_busy, 0);
        check("st_ignored_data", a_dout, 0);
        a_valid = 1'b0; a_ack = 1'b0;
        tick(1);
        check("st_ready_still_lo", a_ready, 0);
        tick(1);
        check("st_ready_hi", a_ready, 1);

        // Normal transfer after the reset
        a_valid = 1'b1; a_din = 16'h600D;
        tick(1);
        a_valid = 1'b0;
        check("pr_req",  a_req,  1);
        check("pr_data", a_dout, 16'h600D);
        a_ack = 1'b1;
        tick(3);
        check("pr_fall", a_req, 0);
        a_ack = 1'b0;
        tick(3);
        check("pr_ready", a_ready, 1);
        check("pr_hold",  a_dout,  16'h600D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
